// File: rtl/joypad_pkg.sv
// Shared button indices and scan FSM encoding for the NES joypad bridge.
package joypad_pkg;

    localparam int unsigned NUM_BTNS  = 8;
    localparam int unsigned BIT_IDX_W = 3;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SAMPLE,
        CLK_HI,
        CLK_LO,
        DONE
    } scan_state_e;

endpackage

// File: rtl/joypad_shift_emu.sv
// Emulates one NES pad's parallel-in/serial-out register toward the CPU joypad port.
module joypad_shift_emu
    import joypad_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                latch_i,
    input  logic                jp_clk_i,
    input  logic [NUM_BTNS-1:0] btns_i,
    output logic                data_o
);

    // Holds the serial line levels directly (active-low), so data_o is a flop output.
    logic [NUM_BTNS-1:0] line_q, line_d;
    logic                clk_q;

    always_comb begin
        line_d = line_q;
        if (latch_i) begin
            line_d = ~btns_i;
        end else if (jp_clk_i && !clk_q) begin
            line_d = {1'b0, line_q[NUM_BTNS-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '1;
            clk_q  <= 1'b0;
        end else begin
            line_q <= line_d;
            clk_q  <= jp_clk_i;
        end
    end

    assign data_o = line_q[BTN_A];

endmodule

// File: rtl/joypad_bridge.sv
// Polls two physical NES pads at a fixed rate and replays the captured state to the CPU port.
module joypad_bridge
    import joypad_pkg::*;
#(
    parameter int unsigned POLL_CYC  = 1_666_667,
    parameter int unsigned LATCH_CYC = 1200,
    parameter int unsigned HALF_CYC  = 600
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                pad_data1_in,
    input  logic                pad_data2_in,
    output logic                pad_clk_out,
    output logic                pad_latch_out,
    input  logic                jp_clk_in,
    input  logic                jp_latch_in,
    output logic                jp_data1_out,
    output logic                jp_data2_out,
    output logic [NUM_BTNS-1:0] btns1_out,
    output logic [NUM_BTNS-1:0] btns2_out,
    output logic                poll_done_out
);

    localparam int unsigned POLL_W  = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int unsigned DLY_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

    scan_state_e          state_q, state_d;
    logic [POLL_W-1:0]    timer_q, timer_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic [BIT_IDX_W-1:0] idx_q, idx_d;
    logic [NUM_BTNS-1:0]  cap1_q, cap1_d, cap2_q, cap2_d;
    logic [NUM_BTNS-1:0]  btns1_q, btns1_d, btns2_q, btns2_d;
    logic                 latch_q, latch_d, pclk_q, pclk_d, done_q, done_d;
    logic [1:0]           sync1_q, sync2_q;
    logic                 tick_c;

    assign tick_c  = (timer_q == POLL_W'(POLL_CYC - 1));
    assign timer_d = tick_c ? '0 : timer_q + POLL_W'(1);

    // Scan sequencer: one shared delay counter times latch, clock-high and clock-low phases.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        idx_d   = idx_q;
        cap1_d  = cap1_q;
        cap2_d  = cap2_q;
        btns1_d = btns1_q;
        btns2_d = btns2_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick_c) begin
                    state_d = LATCH;
                    dly_d   = '0;
                end
            end
            LATCH: begin
                if (dly_q == DLY_W'(LATCH_CYC - 1)) begin
                    state_d = SAMPLE;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            SAMPLE: begin
                cap1_d[0] = ~sync1_q[1];
                cap2_d[0] = ~sync2_q[1];
                idx_d     = BIT_IDX_W'(1);
                state_d   = CLK_HI;
                dly_d     = '0;
            end
            CLK_HI: begin
                if (dly_q == DLY_W'(HALF_CYC - 1)) begin
                    state_d = CLK_LO;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            CLK_LO: begin
                if (dly_q == DLY_W'(HALF_CYC - 1)) begin
                    cap1_d[idx_q] = ~sync1_q[1];
                    cap2_d[idx_q] = ~sync2_q[1];
                    dly_d         = '0;
                    if (idx_q == BIT_IDX_W'(NUM_BTNS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + BIT_IDX_W'(1);
                        state_d = CLK_HI;
                    end
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            DONE: begin
                btns1_d = cap1_q;
                btns2_d = cap2_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pad pins follow the next state so they are glitch-free flop outputs.
    assign latch_d = (state_d == LATCH);
    assign pclk_d  = (state_d == CLK_HI);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            timer_q <= '0;
            dly_q   <= '0;
            idx_q   <= '0;
            cap1_q  <= '0;
            cap2_q  <= '0;
            btns1_q <= '0;
            btns2_q <= '0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b0;
            done_q  <= 1'b0;
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
            cap1_q  <= cap1_d;
            cap2_q  <= cap2_d;
            btns1_q <= btns1_d;
            btns2_q <= btns2_d;
            latch_q <= latch_d;
            pclk_q  <= pclk_d;
            done_q  <= done_d;
            sync1_q <= {sync1_q[0], pad_data1_in};
            sync2_q <= {sync2_q[0], pad_data2_in};
        end
    end

    assign pad_latch_out = latch_q;
    assign pad_clk_out   = pclk_q;
    assign btns1_out     = btns1_q;
    assign btns2_out     = btns2_q;
    assign poll_done_out = done_q;

    joypad_shift_emu u_emu1 (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .latch_i  (jp_latch_in),
        .jp_clk_i (jp_clk_in),
        .btns_i   (btns1_q),
        .data_o   (jp_data1_out)
    );

    joypad_shift_emu u_emu2 (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .latch_i  (jp_latch_in),
        .jp_clk_i (jp_clk_in),
        .btns_i   (btns2_q),
        .data_o   (jp_data2_out)
    );

endmodule
